// File: rtl/c_to_d_stuff_bridge_pkg.sv
// Shared types and constants for the cStuffIf -> dStuffIf bridge.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package c_to_d_stuff_bridge_pkg;

  localparam int SEE_W                = 5;
  localparam int SEQ_W                = 2;
  localparam int D_W                  = SEQ_W + SEE_W;
  localparam int C_TO_D_DEPTH_DEFAULT = 4;

  typedef logic [SEE_W-1:0] see_st_t;

  // Downstream item: sequence tag in the top bits, upstream payload below.
  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    see_st_t          payload;
  } d_st_t;

endpackage

// File: rtl/c_to_d_stuff_fifo.sv
// DEPTH x 5-bit synchronous FIFO with an explicit occupancy counter.
// Latency: a pushed entry is readable on pop_data the cycle after the push.
// Backpressure: caller must not push when full nor pop when empty.
// Ports: clk, rst_n (async active-low); push/push_data write side;
//        pop/pop_data read side (pop_data = head entry); full, empty, level.
module c_to_d_stuff_fifo
  import c_to_d_stuff_bridge_pkg::*;
#(
  parameter int DEPTH = C_TO_D_DEPTH_DEFAULT,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [SEE_W-1:0] push_data,
  input  logic             pop,
  output logic [SEE_W-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [SEE_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Storage is not reset; the top gates the output while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so pointers wrap on natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (level == LVL_W'(DEPTH));
  assign empty    = (level == '0);

endmodule

// File: rtl/c_to_d_stuff_bridge.sv
// Sinks cStuffIf (5-bit seeSt), buffers in a FIFO, sources dStuffIf (7-bit dSt = {seq, payload}).
// Latency: item accepted at edge N is valid downstream after edge N; no empty bypass.
// Backpressure: cStuffIf_rdy drops when full or before the first edge after reset; dStuffIf held while stalled.
// Ports: clk, rst_n (async active-low); cStuffIf_vld/_data/_rdy upstream;
//        dStuffIf_vld/_data/_rdy downstream; level = FIFO occupancy.
// Build option: C_TO_D_BRIDGE_SEQ_EN adds the 2-bit output sequence tag;
//               without it the top bits of dStuffIf_data are zero.
module c_to_d_stuff_bridge
  import c_to_d_stuff_bridge_pkg::*;
#(
  parameter int DEPTH = C_TO_D_DEPTH_DEFAULT,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cStuffIf_vld,
  input  logic [SEE_W-1:0] cStuffIf_data,
  output logic             cStuffIf_rdy,
  output logic             dStuffIf_vld,
  output logic [D_W-1:0]   dStuffIf_data,
  input  logic             dStuffIf_rdy,
  output logic [LVL_W-1:0] level
);

  logic             rst_done;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [SEE_W-1:0] head;
  logic [SEQ_W-1:0] seq;
  d_st_t            d_out;

  // Hold off upstream for one edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_done <= 1'b0;
    else        rst_done <= 1'b1;
  end

  assign cStuffIf_rdy = rst_done & ~full;
  assign dStuffIf_vld = ~empty;
  assign push         = cStuffIf_vld & cStuffIf_rdy;
  assign pop          = dStuffIf_vld & dStuffIf_rdy;

  c_to_d_stuff_fifo #(
    .DEPTH (DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (cStuffIf_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

`ifdef C_TO_D_BRIDGE_SEQ_EN
  // Tags each delivered item; wraps 3 -> 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   seq <= '0;
    else if (pop) seq <= seq + SEQ_W'(1);
  end
`else
  assign seq = '0;
`endif

  // Forced to zero while empty so the reset/idle output is clean.
  always_comb begin
    d_out = '0;
    if (dStuffIf_vld) begin
      d_out.seq     = seq;
      d_out.payload = head;
    end
  end

  assign dStuffIf_data = d_out;

  a_no_push_full : assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
  a_no_pop_empty : assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));
  a_hold_stalled : assert property (@(posedge clk) disable iff (!rst_n)
                     (dStuffIf_vld && !dStuffIf_rdy) |=> (dStuffIf_vld && $stable(dStuffIf_data)));

endmodule
